// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA arithmetic datapath.
// State encoding and counter sizing used by the Montgomery multiplier.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    CORR = 2'd2,
    DONE = 2'd3
  } mm_state_t;

  // Bits needed to count 0..n-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/cond_sub.sv
// Final Montgomery correction: subtract the modulus once when T >= M.
// Kept combinational so the exponentiation engine can reuse it.
module cond_sub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH:0]   i_t,
  input  logic [WIDTH-1:0] i_m,
  output logic [WIDTH-1:0] o_p
);

  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_ge   = (i_t >= {1'b0, i_m});
    w_diff = WIDTH'(i_t - {1'b0, i_m});
    o_p    = w_ge ? w_diff : i_t[WIDTH-1:0];
  end

endmodule

// File: rtl/montgomery_mult.sv
// Bit-serial radix-2 Montgomery multiplier: p = a*b*2^-WIDTH mod m.
// One multiplier bit per enabled cycle, then a single conditional subtract.
module montgomery_mult
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             en,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] m,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] p
);

  localparam int unsigned   CW   = clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mm_state_t        r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH:0]   r_t;
  logic [CW-1:0]    r_cnt;
  logic             r_bad;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_p;

  logic [WIDTH+1:0] w_t1;
  logic [WIDTH+1:0] w_t2;
  logic [WIDTH-1:0] w_sub;
  logic             w_bad_m;

  always_comb begin
    w_t1    = {1'b0, r_t} + (r_a[r_cnt] ? {2'b00, r_b} : '0);
    w_t2    = w_t1 + (w_t1[0] ? {2'b00, r_m} : '0);
    w_bad_m = ~m[0] | (m < WIDTH'(2));
  end

  cond_sub #(.WIDTH(WIDTH)) u_cond_sub (
    .i_t (r_t),
    .i_m (r_m),
    .o_p (w_sub)
  );

  // A bad modulus still passes through CORR so err/done share the CORR->DONE
  // timing; busy is therefore high for one cycle on that path.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_m     <= '0;
      r_t     <= '0;
      r_cnt   <= '0;
      r_bad   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_p     <= '0;
    end else if (en) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_m     <= m;
            r_t     <= '0;
            r_cnt   <= '0;
            r_bad   <= w_bad_m;
            r_err   <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= w_bad_m ? CORR : CALC;
          end
        end
        CALC: begin
          r_t   <= (WIDTH + 1)'(w_t2 >> 1);
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST) r_state <= CORR;
        end
        CORR: begin
          r_p     <= r_bad ? '0 : w_sub;
          r_err   <= r_bad;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= DONE;
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;
  assign p    = r_p;

endmodule

// File: tb/tb_montgomery_mult.sv
// Directed + random bench for montgomery_mult (WIDTH=8) with a result scoreboard.
module tb_montgomery_mult;

  logic       clk = 1'b0;
  logic       rstb;
  logic       en;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] m;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] p;

  typedef struct {
    logic [7:0] p;
    logic       err;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  montgomery_mult #(.WIDTH(8)) dut (
    .clk   (clk),
    .rstb  (rstb),
    .en    (en),
    .start (start),
    .a     (a),
    .b     (b),
    .m     (m),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .p     (p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Smallest x < m with x*256 == a*b (mod m); m odd so x is unique.
  function automatic logic [7:0] ref_p(input int unsigned ai, input int unsigned bi,
                                       input int unsigned mi);
    int unsigned ab;
    ab = (ai * bi) % mi;
    for (int unsigned x = 0; x < mi; x++) begin
      if (((x * 256) % mi) == ab) return 8'(x);
    end
    return 8'hxx;
  endfunction

  task automatic kick(input logic [7:0] ai, input logic [7:0] bi, input logic [7:0] mi,
                      input bit push);
    exp_t e;
    a     = ai;
    b     = bi;
    m     = mi;
    start = 1'b1;
    if (push) begin
      e.err = (mi[0] == 1'b0) || (mi < 8'd2);
      e.p   = e.err ? 8'h00 : ref_p(ai, bi, mi);
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input int en_off,
                           input int poke_at, input bit hold_done);
    int   n;
    int   nb;
    bit   seen;
    exp_t e;
    n    = 0;
    nb   = 0;
    seen = 1'b0;
    while (!seen && n < 60) begin
      @(negedge clk);
      start = 1'b0;
      n++;
      if (n == 1) begin
        chk({tag, "/busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, "/err_cleared"}, 32'(err), 32'd0);
      end
      if (busy) nb++;
      if (done) seen = 1'b1;
      else begin
        if (en_off != 0 && n == en_off) en = 1'b0;
        if (en_off != 0 && n == en_off + 3) en = 1'b1;
        if (poke_at != 0 && n == poke_at) begin
          a = 8'd2; b = 8'd3; m = 8'd11; start = 1'b1;
        end
      end
    end
    chk({tag, "/done_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    chk({tag, "/latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "/busy_cycles"}, 32'(nb), 32'(exp_lat - 1));
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
    chk({tag, "/sb_nonempty"}, 32'(sbq.size() > 0), 32'd1);
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, "/p"}, 32'(p), 32'(e.p));
      chk({tag, "/err"}, 32'(err), 32'(e.err));
    end
    if (hold_done) begin
      en = 1'b0;
      @(negedge clk);
      chk({tag, "/done_hold1"}, 32'(done), 32'd1);
      @(negedge clk);
      chk({tag, "/done_hold2"}, 32'(done), 32'd1);
      en = 1'b1;
    end
    @(negedge clk);
    chk({tag, "/done_pulse_end"}, 32'(done), 32'd0);
  endtask

  initial begin
    int         ndone;
    logic [7:0] rm;
    logic [7:0] ra;
    logic [7:0] rb;

    rstb  = 1'b0;
    en    = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    m     = '0;
    #12;
    chk("reset/busy", 32'(busy), 32'd0);
    chk("reset/done", 32'(done), 32'd0);
    chk("reset/err",  32'(err),  32'd0);
    chk("reset/p",    32'(p),    32'd0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);

    kick(8'd5, 8'd7, 8'd13, 1'b1);    wait_done("basic_5x7", 10, 0, 0, 1'b0);
    kick(8'd1, 8'd9, 8'd13, 1'b1);    wait_done("one_x_R", 10, 0, 0, 1'b0);
    kick(8'd0, 8'd7, 8'd13, 1'b1);    wait_done("zero_a", 10, 0, 0, 1'b0);
    kick(8'd254, 8'd254, 8'd255, 1'b1); wait_done("max_width", 10, 0, 0, 1'b0);
    kick(8'd3, 8'd4, 8'd12, 1'b1);    wait_done("even_m", 2, 0, 0, 1'b0);
    kick(8'd5, 8'd7, 8'd13, 1'b1);    wait_done("err_recover", 10, 0, 0, 1'b0);
    kick(8'd0, 8'd0, 8'd1, 1'b1);     wait_done("m_one", 2, 0, 0, 1'b0);
    kick(8'd5, 8'd7, 8'd13, 1'b1);    wait_done("en_freeze", 13, 3, 0, 1'b1);
    kick(8'd5, 8'd7, 8'd13, 1'b1);    wait_done("start_busy", 10, 0, 4, 1'b0);

    kick(8'd5, 8'd7, 8'd13, 1'b0);
    repeat (4) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("rst_mid/busy_before", 32'(busy), 32'd1);
    rstb = 1'b0;
    #1;
    chk("rst_mid/busy", 32'(busy), 32'd0);
    chk("rst_mid/done", 32'(done), 32'd0);
    chk("rst_mid/err",  32'(err),  32'd0);
    chk("rst_mid/p",    32'(p),    32'd0);
    @(negedge clk);
    rstb  = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("rst_mid/no_done", 32'(ndone), 32'd0);
    chk("rst_mid/idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 1000; i++) begin
      rm = 8'($urandom_range(1, 127) * 2 + 1);
      ra = 8'($urandom_range(0, 32'(rm) - 1));
      rb = 8'($urandom_range(0, 32'(rm) - 1));
      kick(ra, rb, rm, 1'b1);
      wait_done("random", 10, 0, 0, 1'b0);
    end

    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
